axil_cmd_initiator: RTL



---
 rtl/axil_cmd_initiator.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_cmd_initiator.sv
// axil_cmd_initiator: AXI-Lite manager that turns a valid/ready command stream
// into single AXI-Lite reads or writes, one transaction outstanding at a time,
// and returns each result on a valid/ready response stream.
//
// Optional build macro AXIL_INIT_TIMEOUT_EN: adds a watchdog that aborts a stalled
// transaction after TIMEOUT_CYCLES busy cycles. It then returns rsp_resp 2'b11 and
// locks the block in a fault state, which only rst_n clears. Without the macro the
// block waits on the slave indefinitely and TIMEOUT_CYCLES is unused.

module axil_cmd_initiator #(
    parameter int unsigned AXIL_ADDR_WIDTH = 32,
    parameter int unsigned AXIL_DATA_WIDTH = 32,
    parameter int unsigned AXIL_STRB_WIDTH = AXIL_DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                       clk,
    input  logic                       rst_n,

    // Command stream
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_wr,
    input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AXIL_DATA_WIDTH-1:0] cmd_wdata,

    // Response stream
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [AXIL_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                 rsp_resp,

    // AXI-Lite write address channel
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic                       m_axil_awvalid,
    input  logic                       m_axil_awready,

    // AXI-Lite write data channel
    output logic [AXIL_DATA_WIDTH-1:0] m_axil_wdata,
    output logic [AXIL_STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                       m_axil_wvalid,
    input  logic                       m_axil_wready,

    // AXI-Lite write response channel
    input  logic                       m_axil_bvalid,
    input  logic [1:0]                 m_axil_bresp,
    output logic                       m_axil_bready,

    // AXI-Lite read address channel
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,

    // AXI-Lite read data channel
    input  logic                       m_axil_rvalid,
    input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    output logic                       m_axil_rready
);

    // Reject configurations the datapath cannot represent.
    if ((AXIL_DATA_WIDTH % 8) != 0 || AXIL_STRB_WIDTH != AXIL_DATA_WIDTH / 8 ||
        TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("axil_cmd_initiator: invalid parameter combination");
    end

`ifdef AXIL_INIT_TIMEOUT_EN
    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWaitB,
        StRd,
        StWaitR,
        StRsp,
        StFault
    } state_e;

    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

    logic [TimerWidth-1:0] timer_q;
    logic                  timed_out_q;
    logic                  busy;
`else
    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StWaitB,
        StRd,
        StWaitR,
        StRsp
    } state_e;
`endif

    state_e state_q;
    logic   aw_done_q;
    logic   w_done_q;
    logic   aw_fin;
    logic   w_fin;

    // A write phase counts as finished if it completed earlier or handshakes this cycle.
    always_comb begin
        aw_fin = aw_done_q | (m_axil_awvalid & m_axil_awready);
        w_fin  = w_done_q  | (m_axil_wvalid  & m_axil_wready);
`ifdef AXIL_INIT_TIMEOUT_EN
        busy   = (state_q == StWr) || (state_q == StWaitB) ||
                 (state_q == StRd) || (state_q == StWaitR);
`endif
    end

    // Transaction sequencer; every output is a register written only here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            aw_done_q      <= 1'b0;
            w_done_q       <= 1'b0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= 2'b00;
            m_axil_awaddr  <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_araddr  <= '0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
`ifdef AXIL_INIT_TIMEOUT_EN
            timer_q        <= '0;
            timed_out_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    // cmd_ready comes up one cycle after reset release.
                    if (!cmd_ready) begin
                        cmd_ready <= 1'b1;
                    end else if (cmd_valid) begin
                        cmd_ready <= 1'b0;
`ifdef AXIL_INIT_TIMEOUT_EN
                        timer_q   <= '0;
`endif
                        if (cmd_wr) begin
                            m_axil_awaddr  <= cmd_addr;
                            m_axil_wdata   <= cmd_wdata;
                            m_axil_wstrb   <= '1;
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            aw_done_q      <= 1'b0;
                            w_done_q       <= 1'b0;
                            state_q        <= StWr;
                        end else begin
                            m_axil_araddr  <= cmd_addr;
                            m_axil_arvalid <= 1'b1;
                            state_q        <= StRd;
                        end
                    end
                end

                StWr: begin
                    // AW and W retire independently; B is awaited once both are done.
                    if (m_axil_awvalid && m_axil_awready) begin
                        m_axil_awvalid <= 1'b0;
                        aw_done_q      <= 1'b1;
                    end
                    if (m_axil_wvalid && m_axil_wready) begin
                        m_axil_wvalid <= 1'b0;
                        w_done_q      <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        m_axil_bready <= 1'b1;
                        state_q       <= StWaitB;
                    end
                end

                StWaitB: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        rsp_resp      <= m_axil_bresp;
                        rsp_rdata     <= '0;
                        rsp_valid     <= 1'b1;
                        state_q       <= StRsp;
                    end
                end

                StRd: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        state_q        <= StWaitR;
                    end
                end

                StWaitR: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        rsp_rdata     <= m_axil_rdata;
                        rsp_resp      <= m_axil_rresp;
                        rsp_valid     <= 1'b1;
                        state_q       <= StRsp;
                    end
                end

                StRsp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
`ifdef AXIL_INIT_TIMEOUT_EN
                        if (timed_out_q) begin
                            state_q <= StFault;
                        end else begin
                            cmd_ready <= 1'b1;
                            state_q   <= StIdle;
                        end
`else
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
`endif
                    end
                end

`ifdef AXIL_INIT_TIMEOUT_EN
                StFault: begin
                    cmd_ready <= 1'b0;
                end
`endif

                default: begin
                    state_q <= StIdle;
                end
            endcase

`ifdef AXIL_INIT_TIMEOUT_EN
            // Watchdog overrides whatever the busy state decided on its final cycle.
            if (busy) begin
                timer_q <= timer_q + 1'b1;
                if (timer_q == TimerLast) begin
                    m_axil_awvalid <= 1'b0;
                    m_axil_wvalid  <= 1'b0;
                    m_axil_bready  <= 1'b0;
                    m_axil_arvalid <= 1'b0;
                    m_axil_rready  <= 1'b0;
                    rsp_resp       <= 2'b11;
                    rsp_rdata      <= '0;
                    rsp_valid      <= 1'b1;
                    timed_out_q    <= 1'b1;
                    state_q        <= StRsp;
                end
            end
`endif
        end
    end

endmodule
